// File: rtl/nx_ia_sram_arbiter_if.sv
// Bundles the software, hardware and RAM-side signals of the SRAM arbiter.
// The arbiter takes the slave view; the surrounding environment takes the master view.
interface nx_ia_sram_arbiter_if #(
  parameter int N_DATA_BITS = 38,
  parameter int N_ADDR_BITS = 14
);
  // software (indirect-access controller) port
  logic                   sw_cs;
  logic                   sw_we;
  logic [N_ADDR_BITS-1:0] sw_add;
  logic [N_DATA_BITS-1:0] sw_wdat;
  logic                   sw_yield;
  logic                   sw_reset;
  logic                   grant;
  logic                   rsp;
  logic [N_DATA_BITS-1:0] sw_rdat;

  // hardware (datapath) port
  logic                   hw_req;
  logic                   hw_we;
  logic [N_ADDR_BITS-1:0] hw_add;
  logic [N_DATA_BITS-1:0] hw_wdat;
  logic                   hw_gnt;
  logic                   hw_rvld;
  logic [N_DATA_BITS-1:0] hw_rdat;

  // single-port RAM
  logic                   mem_cs;
  logic                   mem_we;
  logic [N_ADDR_BITS-1:0] mem_add;
  logic [N_DATA_BITS-1:0] mem_wdat;
  logic [N_DATA_BITS-1:0] mem_rdat;

  modport slave (
    input  sw_cs, sw_we, sw_add, sw_wdat, sw_yield, sw_reset,
    output grant, rsp, sw_rdat,
    input  hw_req, hw_we, hw_add, hw_wdat,
    output hw_gnt, hw_rvld, hw_rdat,
    output mem_cs, mem_we, mem_add, mem_wdat,
    input  mem_rdat
  );

  modport master (
    output sw_cs, sw_we, sw_add, sw_wdat, sw_yield, sw_reset,
    input  grant, rsp, sw_rdat,
    output hw_req, hw_we, hw_add, hw_wdat,
    input  hw_gnt, hw_rvld, hw_rdat,
    input  mem_cs, mem_we, mem_add, mem_wdat,
    output mem_rdat
  );
endinterface

// File: rtl/nx_ia_sram_arbiter.sv
// Single-port SRAM arbiter merging the indirect-access software port with the
// datapath hardware port, with a fairness counter bounding hardware bursts.
module nx_ia_sram_arbiter #(
  parameter int N_DATA_BITS  = 38,
  parameter int N_ADDR_BITS  = 14,
  parameter int RD_LATENCY   = 1,
  parameter int MAX_HW_BURST = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nx_ia_sram_arbiter_if.slave    bus
);

  localparam int         PIPE_DEPTH = RD_LATENCY + 1;
  localparam int         TOP        = PIPE_DEPTH - 1;
  localparam logic [7:0] BURST_MAX  = 8'(MAX_HW_BURST);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [7:0] burst_q, burst_d;
  logic       sw_wins;
  logic       hw_wins;

  // Grants are gated by reset so nothing is accepted while rst_n is low.
  assign sw_wins = rst_n && bus.sw_cs &&
                   (bus.sw_yield || bus.sw_reset || !bus.hw_req || burst_q == BURST_MAX);
  assign hw_wins = rst_n && bus.hw_req && !sw_wins;

  assign bus.grant  = sw_wins;
  assign bus.hw_gnt = hw_wins;

  always_comb begin
    burst_d = burst_q;
    if (sw_wins || !bus.sw_cs) begin
      burst_d = '0;
    end else if (hw_wins && burst_q != BURST_MAX) begin
      burst_d = burst_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Command stage
  // ---------------------------------------------------------------------------
  logic                   mem_cs_q,   mem_cs_d;
  logic                   mem_we_q,   mem_we_d;
  logic [N_ADDR_BITS-1:0] mem_add_q,  mem_add_d;
  logic [N_DATA_BITS-1:0] mem_wdat_q, mem_wdat_d;

  always_comb begin
    mem_cs_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_add_d  = mem_add_q;
    mem_wdat_d = mem_wdat_q;
    if (sw_wins) begin
      mem_cs_d   = 1'b1;
      mem_we_d   = bus.sw_we;
      mem_add_d  = bus.sw_add;
      mem_wdat_d = bus.sw_wdat;
    end else if (hw_wins) begin
      mem_cs_d   = 1'b1;
      mem_we_d   = bus.hw_we;
      mem_add_d  = bus.hw_add;
      mem_wdat_d = bus.hw_wdat;
    end
  end

  assign bus.mem_cs   = mem_cs_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_add  = mem_add_q;
  assign bus.mem_wdat = mem_wdat_q;

  // ---------------------------------------------------------------------------
  // Response pipeline: stage k is occupied during cycle T+1+k of a read granted at T
  // ---------------------------------------------------------------------------
  logic [PIPE_DEPTH-1:0] vld_q, vld_d;
  logic [PIPE_DEPTH-1:0] is_sw_q, is_sw_d;

  assign vld_d[0]   = (sw_wins && !bus.sw_we) || (hw_wins && !bus.hw_we);
  assign is_sw_d[0] = sw_wins;

  for (genvar gi = 1; gi < PIPE_DEPTH; gi++) begin : g_pipe
    assign vld_d[gi]   = vld_q[gi-1];
    assign is_sw_d[gi] = is_sw_q[gi-1];
  end

  logic                   rsp_q,     rsp_d;
  logic                   hw_rvld_q, hw_rvld_d;
  logic [N_DATA_BITS-1:0] sw_rdat_q, sw_rdat_d;
  logic [N_DATA_BITS-1:0] hw_rdat_q, hw_rdat_d;

  // The last stage lines up with valid RAM data; capture it for the owner.
  always_comb begin
    rsp_d     = vld_q[TOP] && is_sw_q[TOP];
    hw_rvld_d = vld_q[TOP] && !is_sw_q[TOP];
    sw_rdat_d = rsp_d     ? bus.mem_rdat : sw_rdat_q;
    hw_rdat_d = hw_rvld_d ? bus.mem_rdat : hw_rdat_q;
  end

  assign bus.rsp     = rsp_q;
  assign bus.sw_rdat = sw_rdat_q;
  assign bus.hw_rvld = hw_rvld_q;
  assign bus.hw_rdat = hw_rdat_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_q    <= '0;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_add_q  <= '0;
      mem_wdat_q <= '0;
      vld_q      <= '0;
      is_sw_q    <= '0;
      rsp_q      <= 1'b0;
      hw_rvld_q  <= 1'b0;
      sw_rdat_q  <= '0;
      hw_rdat_q  <= '0;
    end else begin
      burst_q    <= burst_d;
      mem_cs_q   <= mem_cs_d;
      mem_we_q   <= mem_we_d;
      mem_add_q  <= mem_add_d;
      mem_wdat_q <= mem_wdat_d;
      vld_q      <= vld_d;
      is_sw_q    <= is_sw_d;
      rsp_q      <= rsp_d;
      hw_rvld_q  <= hw_rvld_d;
      sw_rdat_q  <= sw_rdat_d;
      hw_rdat_q  <= hw_rdat_d;
    end
  end

endmodule

// File: tb/tb_nx_ia_sram_arbiter.sv
// Randomized bench for nx_ia_sram_arbiter: a transaction-level model predicts
// grants, RAM commands and read responses from the arbitration rules.
module tb_nx_ia_sram_arbiter;

  localparam int DW  = 38;
  localparam int AW  = 14;
  localparam int RL  = 1;
  localparam int MAX = 8;
  localparam int N_CYCLES = 1600;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nx_ia_sram_arbiter_if #(.N_DATA_BITS(DW), .N_ADDR_BITS(AW)) bus ();

  nx_ia_sram_arbiter #(
    .N_DATA_BITS (DW),
    .N_ADDR_BITS (AW),
    .RD_LATENCY  (RL),
    .MAX_HW_BURST(MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Write-first single-port RAM with RL cycles of read latency.
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [RL];

  always @(posedge clk) begin
    if (bus.mem_cs) begin
      if (bus.mem_we) begin
        ram[bus.mem_add] <= bus.mem_wdat;
        rd_pipe[0]       <= bus.mem_wdat;
      end else begin
        rd_pipe[0] <= ram[bus.mem_add];
      end
    end
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdat = rd_pipe[RL-1];

  // Reference state
  typedef struct {
    int            due;
    bit            is_sw;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         resp_q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            burst_m;
  logic          exp_cs, exp_we;
  logic [AW-1:0] exp_add;
  logic [DW-1:0] exp_wdat, exp_sw_rdat, exp_hw_rdat;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E37_79B1;
    return {6'(a), h};
  endfunction

  initial begin
    int  cyc;
    bit  last_grant;
    bit  exp_rsp, exp_hwv, eg, hg, sw_wins;
    resp_t r;

    for (int a = 0; a < (1 << AW); a++) begin
      ram[a]     = init_word(a);
      ref_mem[a] = init_word(a);
    end

    rst_n        = 1'b0;
    bus.sw_cs    = 1'b0;
    bus.sw_we    = 1'b0;
    bus.sw_add   = '0;
    bus.sw_wdat  = '0;
    bus.sw_yield = 1'b0;
    bus.sw_reset = 1'b0;
    bus.hw_req   = 1'b0;
    bus.hw_we    = 1'b0;
    bus.hw_add   = '0;
    bus.hw_wdat  = '0;
    repeat (2) @(posedge clk);

    burst_m     = 0;
    exp_cs      = 1'b0;
    exp_we      = 1'b0;
    exp_add     = '0;
    exp_wdat    = '0;
    exp_sw_rdat = '0;
    exp_hw_rdat = '0;
    last_grant  = 1'b0;
    cyc         = 0;

    while (cyc < N_CYCLES) begin
      @(posedge clk);
      #1;
      cyc++;

      // Registered outputs from the previous cycle's decision
      check_val("mem_cs", 64'(bus.mem_cs), 64'(exp_cs));
      check_val("mem_we", 64'(bus.mem_we), 64'(exp_we));
      check_val("mem_add", 64'(bus.mem_add), 64'(exp_add));
      check_val("mem_wdat", 64'(bus.mem_wdat), 64'(exp_wdat));

      exp_rsp = 1'b0;
      exp_hwv = 1'b0;
      if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
        r = resp_q.pop_front();
        if (r.is_sw) begin
          exp_rsp     = 1'b1;
          exp_sw_rdat = r.data;
        end else begin
          exp_hwv     = 1'b1;
          exp_hw_rdat = r.data;
        end
      end
      check_val("rsp", 64'(bus.rsp), 64'(exp_rsp));
      check_val("hw_rvld", 64'(bus.hw_rvld), 64'(exp_hwv));
      check_val("sw_rdat", 64'(bus.sw_rdat), 64'(exp_sw_rdat));
      check_val("hw_rdat", 64'(bus.hw_rdat), 64'(exp_hw_rdat));

      // Stimulus: software request is held until granted
      rst_n = !(cyc > 20 && cyc < N_CYCLES - 20 && $urandom_range(0, 99) == 0);
      if (!bus.sw_cs || last_grant) begin
        bus.sw_cs   = ($urandom_range(0, 99) < 60);
        bus.sw_we   = $urandom_range(0, 1) == 1;
        bus.sw_add  = AW'($urandom_range(0, 31));
        bus.sw_wdat = DW'({$urandom(), $urandom()});
      end
      bus.hw_req   = ($urandom_range(0, 1) == 1);
      bus.hw_we    = ($urandom_range(0, 1) == 1);
      bus.hw_add   = AW'($urandom_range(0, 31));
      bus.hw_wdat  = DW'({$urandom(), $urandom()});
      bus.sw_yield = ($urandom_range(0, 9) == 0);
      bus.sw_reset = ($urandom_range(0, 19) == 0);

      if (cyc >= 400 && cyc < 700) begin
        // sustained contention without priority overrides
        bus.hw_req   = 1'b1;
        bus.sw_yield = 1'b0;
        bus.sw_reset = 1'b0;
        if (last_grant) bus.sw_cs = 1'b1;
      end else if (cyc >= 800 && cyc < 816) begin
        // init sweep
        rst_n        = 1'b1;
        bus.sw_cs    = 1'b1;
        bus.sw_we    = 1'b1;
        bus.sw_reset = 1'b1;
        bus.hw_req   = 1'b1;
      end else if (cyc >= N_CYCLES - 12) begin
        bus.sw_cs  = 1'b0;
        bus.hw_req = 1'b0;
      end

      #1;
      if (!rst_n) begin
        eg = 1'b0;
        hg = 1'b0;
      end else begin
        sw_wins = bus.sw_cs &&
                  (bus.sw_yield || bus.sw_reset || !bus.hw_req || burst_m == MAX);
        eg = sw_wins;
        hg = bus.hw_req && !sw_wins;
      end
      check_val("grant", 64'(bus.grant), 64'(eg));
      check_val("hw_gnt", 64'(bus.hw_gnt), 64'(hg));
      if (cyc % 50 == 0)
        $display("cyc %0d: sw_cs=%0b hw_req=%0b grant=%0b hw_gnt=%0b burst=%0d pending_rd=%0d",
                 cyc, bus.sw_cs, bus.hw_req, eg, hg, burst_m, resp_q.size());

      // Advance the model across the coming edge
      last_grant = eg;
      if (!rst_n) begin
        burst_m     = 0;
        exp_cs      = 1'b0;
        exp_we      = 1'b0;
        exp_add     = '0;
        exp_wdat    = '0;
        exp_sw_rdat = '0;
        exp_hw_rdat = '0;
        resp_q.delete();
      end else begin
        if (eg || hg) begin
          exp_cs   = 1'b1;
          exp_we   = eg ? bus.sw_we   : bus.hw_we;
          exp_add  = eg ? bus.sw_add  : bus.hw_add;
          exp_wdat = eg ? bus.sw_wdat : bus.hw_wdat;
          if (exp_we) begin
            ref_mem[exp_add] = exp_wdat;
          end else begin
            r.due   = cyc + 2 + RL;
            r.is_sw = eg;
            r.data  = ref_mem[exp_add];
            resp_q.push_back(r);
          end
        end else begin
          exp_cs = 1'b0;
          exp_we = 1'b0;
        end
        if (eg || !bus.sw_cs) burst_m = 0;
        else if (hg && burst_m < MAX) burst_m++;
      end
    end

    check_val("drained", 64'(resp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nx_ia_sram_arbiter.md
Name: nx_ia_sram_arbiter

Overview:
- Single-port SRAM arbiter sitting directly downstream of the indirect-access controller.
- Merges the controller's software port (cs/we/add/wdat, yield, reset) with the datapath's hardware port onto one single-port RAM.
- Returns grant and read response (rsp, rdat) to the controller, and grant plus read-valid to the datapath.
- Fairness counter prevents hardware traffic from starving software accesses.

Parameters:
- N_DATA_BITS, 38, RAM word width.
- N_ADDR_BITS, 14, RAM address width.
- RD_LATENCY, 1, cycles from mem_cs to mem_rdat valid; legal 1..4.
- MAX_HW_BURST, 8, consecutive hw grants allowed while sw_cs pending; legal 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- sw_cs  in  1  software access request, held until granted.
- sw_we  in  1  software write (1) / read (0).
- sw_add  in  N_ADDR_BITS  software address.
- sw_wdat  in  N_DATA_BITS  software write data.
- sw_yield  in  1  controller starving; forces software priority.
- sw_reset  in  1  controller reset/init sweep active; forces software priority.
- grant  out  1  software request accepted this cycle (combinational).
- rsp  out  1  software read data valid, 1-cycle pulse.
- sw_rdat  out  N_DATA_BITS  software read data, held between rsp pulses.
- hw_req  in  1  datapath access request.
- hw_we  in  1  datapath write / read.
- hw_add  in  N_ADDR_BITS  datapath address.
- hw_wdat  in  N_DATA_BITS  datapath write data.
- hw_gnt  out  1  datapath request accepted this cycle (combinational).
- hw_rvld  out  1  datapath read data valid, 1-cycle pulse.
- hw_rdat  out  N_DATA_BITS  datapath read data, held.
- mem_cs  out  1  RAM chip select (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_add  out  N_ADDR_BITS  RAM address (registered).
- mem_wdat  out  N_DATA_BITS  RAM write data (registered).
- mem_rdat  in  N_DATA_BITS  RAM read data.

Behaviour:
- **Reset.** rst_n sampled low at a clk edge gives:
  - all outputs 0: grant/hw_gnt go to 0 combinationally while rst_n is low;
  - response pipeline cleared, fairness counter 0.
  - Reads in flight when reset hits never produce rsp/hw_rvld.
- **Arbitration (combinational, same cycle).**
  - sw_wins = sw_cs && (sw_yield || sw_reset || !hw_req || burst_cnt == MAX_HW_BURST).
  - grant = sw_wins.
  - hw_gnt = hw_req && !sw_wins.
  - Exactly one, or neither, granted per cycle; at most one RAM access per cycle.
- **Fairness counter** burst_cnt (8 bits, saturating at MAX_HW_BURST):
  - increments on each hw_gnt while sw_cs is high;
  - clears on grant, or on any cycle with sw_cs low.
- **Command stage.** In the cycle after a grant (T+1), mem_cs=1, and mem_we/mem_add/mem_wdat carry the winner's values. With no grant, mem_cs=0 and mem_we=0; mem_add/mem_wdat hold their previous values.
- **Response pipeline.**
  - Shift register of depth RD_LATENCY+1 carries {valid, is_sw} for read grants only; writes push valid=0.
  - Read granted at T: mem_rdat sampled at end of cycle T+1+RD_LATENCY.
  - At T+2+RD_LATENCY the data appears on sw_rdat with rsp=1, or on hw_rdat with hw_rvld=1.
  - Back-to-back reads are fully pipelined (one per cycle); order is preserved.
- **Write/read hazard.** A write granted at T followed by a read of the same address at T+1 returns the new data; the RAM is write-first and the arbiter adds no forwarding.
- **sw_reset sweep.** The controller holds sw_cs continuously; software wins every cycle and hw_gnt stays 0 for the whole sweep.
- **Simultaneous requests.** sw_cs=1 and hw_req=1 with yield/reset low and burst_cnt < MAX_HW_BURST: hardware wins.
- **Unsupported.** No CAM compare support: the controller's compare enable is not an input here. The integrator ties the controller's sw_match to 0 and sw_aindex to 0.
- **Latency summary.**
  - grant to mem_cs: 1 cycle.
  - grant to rsp/hw_rvld: RD_LATENCY+2 cycles.
  - Requestors wait unbounded only while the other side is legitimately prioritised.

Test Plan:
1. Reset mid-read:
   - Stimulus: sw read granted at T, rst_n low at T+1 for 1 cycle.
   - Required: no rsp ever; sw_rdat=0; mem_cs=0 at T+2.
2. Isolated sw read, RD_LATENCY=1:
   - Stimulus: sw_cs=1, sw_we=0, sw_add=0x0123, hw_req=0; RAM holds 0x2A_BCDE_F012 at that address.
   - Required: grant at T; mem_cs=1, mem_add=0x0123 at T+1; rsp=1 with sw_rdat=0x2A_BCDE_F012 at T+3.
3. Contention and fairness, MAX_HW_BURST=8:
   - Stimulus: hw_req and sw_cs both held high, yield low.
   - Required: hw_gnt on 8 consecutive cycles, then grant on the 9th; burst_cnt returns to 0 and the pattern repeats.
4. Yield override:
   - Stimulus: hw_req=1, sw_cs=1, sw_yield=1 with burst_cnt=2.
   - Required: grant=1, hw_gnt=0 that same cycle.
5. Interleaved reads:
   - Stimulus: hw read A at T, sw read B at T+1, hw write A at T+2.
   - Required: hw_rvld at T+3 with old A data; rsp at T+4 with B data; no response for the write.
6. Sweep:
   - Stimulus: sw_reset=1, sw_cs=1, sw_we=1 for 16 cycles, hw_req=1 throughout.
   - Required: 16 grants; hw_gnt=0 for all 16 cycles; mem_we=1 on 16 consecutive cycles.
